// File: rtl/log2_pkg.sv
// Shared sizing helpers for the normalize/log2 family of blocks: norm-count
// width and how shift steps are distributed over pipeline stages.
package log2_pkg;

    function automatic int norm_width(input int width);
        return (width > 32'sd1) ? $clog2(width) : 32'sd1;
    endfunction

    function automatic int num_stages(input int width, input int steps_per_stage);
        int steps;
        steps = norm_width(width);
        return (steps + steps_per_stage - 32'sd1) / steps_per_stage;
    endfunction

    // Steps handled by a given stage; the last stage may carry fewer.
    function automatic int stage_steps(input int width, input int steps_per_stage, input int stage);
        int remaining;
        remaining = norm_width(width) - (stage * steps_per_stage);
        return (remaining < steps_per_stage) ? remaining : steps_per_stage;
    endfunction

endpackage

// File: rtl/normalize_pipe_if.sv
// Stream interface of normalize_pipe: operand in, normalized operand and
// shift count out, valid/ready on both sides.
interface normalize_pipe_if #(
    parameter int WIDTH = 16
);
    import log2_pkg::*;

    localparam int NORM_W = norm_width(WIDTH);

    logic [WIDTH-1:0]  data_i;
    logic              valid_i;
    logic              ready_o;
    logic [WIDTH-1:0]  data_o;
    logic [NORM_W-1:0] norm_o;
    logic              zero_o;
    logic              valid_o;
    logic              ready_i;

    modport slave (
        input  data_i, valid_i, ready_i,
        output ready_o, data_o, norm_o, zero_o, valid_o
    );

    modport master (
        output data_i, valid_i, ready_i,
        input  ready_o, data_o, norm_o, zero_o, valid_o
    );

endinterface

// File: rtl/norm_stage.sv
// One registered normalization stage: NUM_STEPS consecutive conditional
// shift steps starting at FIRST_STEP, then a register bank gated by i_en.
module norm_stage
    import log2_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int SIGNED     = 0,
    parameter int FIRST_STEP = 0,
    parameter int NUM_STEPS  = 1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         i_en,
    input  logic                         i_valid,
    input  logic [WIDTH-1:0]             i_data,
    input  logic [norm_width(WIDTH)-1:0] i_norm,
    input  logic                         i_zero,
    output logic                         o_valid,
    output logic [WIDTH-1:0]             o_data,
    output logic [norm_width(WIDTH)-1:0] o_norm,
    output logic                         o_zero
);

    localparam int NW = norm_width(WIDTH);

    logic [NUM_STEPS:0][WIDTH-1:0] w_d;
    logic [NUM_STEPS:0][NW-1:0]    w_n;
    logic [NUM_STEPS-1:0]          w_hit;

    logic              r_valid;
    logic [WIDTH-1:0]  r_data;
    logic [NW-1:0]     r_norm;
    logic              r_zero;

    assign w_d[0] = i_data;
    assign w_n[0] = i_norm;

    for (genvar j = 0; j < NUM_STEPS; j++) begin : g_step
        localparam int S = WIDTH >> (FIRST_STEP + j + 1);

        // Signed mode keeps one copy of the sign, so it tests S+1 bits.
        if (SIGNED != 0) begin : g_sgn
            assign w_hit[j] = (&w_d[j][WIDTH-1 -: S+1]) | ~(|w_d[j][WIDTH-1 -: S+1]);
        end else begin : g_uns
            assign w_hit[j] = ~(|w_d[j][WIDTH-1 -: S]);
        end

        assign w_d[j+1] = w_hit[j] ? (w_d[j] << S) : w_d[j];
        assign w_n[j+1] = w_hit[j] ? (w_n[j] + NW'(S)) : w_n[j];
    end

    // Stage register; every field, valid included, advances only on i_en.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_norm  <= '0;
            r_zero  <= 1'b0;
        end else if (i_en) begin
            r_valid <= i_valid;
            r_data  <= w_d[NUM_STEPS];
            r_norm  <= w_n[NUM_STEPS];
            r_zero  <= i_zero;
        end else begin
            r_valid <= r_valid;
            r_data  <= r_data;
            r_norm  <= r_norm;
            r_zero  <= r_zero;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_norm  = r_norm;
    assign o_zero  = r_zero;

endmodule

// File: rtl/normalize_pipe.sv
// Pipelined leading-one / leading-sign normalizer with a single global
// enable: the whole pipe moves together or holds together.
module normalize_pipe
    import log2_pkg::*;
#(
    parameter int WIDTH           = 16,
    parameter int STEPS_PER_STAGE = 1,
    parameter int SIGNED          = 0
) (
    input  logic            clock,
    input  logic            reset_n,
    normalize_pipe_if.slave bus
);

    localparam int NW     = norm_width(WIDTH);
    localparam int STAGES = num_stages(WIDTH, STEPS_PER_STAGE);

    logic [STAGES:0]           w_valid;
    logic [STAGES:0][WIDTH-1:0] w_data;
    logic [STAGES:0][NW-1:0]   w_norm;
    logic [STAGES:0]           w_zero;
    logic                      w_en;
    logic                      w_zero_in;

    // Degenerate inputs are flagged up front and carried with the data.
    assign w_zero_in = (SIGNED != 0) ? ((bus.data_i == '0) | (&bus.data_i))
                                     : (bus.data_i == '0);

    assign w_en        = bus.ready_i | ~w_valid[STAGES];
    assign bus.ready_o = w_en;

    assign w_valid[0] = bus.valid_i;
    assign w_data[0]  = bus.data_i;
    assign w_norm[0]  = '0;
    assign w_zero[0]  = w_zero_in;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        norm_stage #(
            .WIDTH      (WIDTH),
            .SIGNED     (SIGNED),
            .FIRST_STEP (s * STEPS_PER_STAGE),
            .NUM_STEPS  (stage_steps(WIDTH, STEPS_PER_STAGE, s))
        ) u_stage (
            .clock   (clock),
            .reset_n (reset_n),
            .i_en    (w_en),
            .i_valid (w_valid[s]),
            .i_data  (w_data[s]),
            .i_norm  (w_norm[s]),
            .i_zero  (w_zero[s]),
            .o_valid (w_valid[s+1]),
            .o_data  (w_data[s+1]),
            .o_norm  (w_norm[s+1]),
            .o_zero  (w_zero[s+1])
        );
    end

    assign bus.valid_o = w_valid[STAGES];
    assign bus.data_o  = w_data[STAGES];
    assign bus.norm_o  = w_norm[STAGES];
    assign bus.zero_o  = w_zero[STAGES];

endmodule

// File: tb/tb_normalize_pipe.sv
// Directed and stream test of normalize_pipe at WIDTH=16 in four
// configurations (1/2/4 steps per stage unsigned, 1 step per stage signed).
module tb_normalize_pipe;

    logic clock;
    logic reset_n;

    int n_checks = 0;
    int n_fail   = 0;

    normalize_pipe_if #(.WIDTH(16)) if_u1 ();
    normalize_pipe_if #(.WIDTH(16)) if_u2 ();
    normalize_pipe_if #(.WIDTH(16)) if_u4 ();
    normalize_pipe_if #(.WIDTH(16)) if_s1 ();

    normalize_pipe #(.WIDTH(16), .STEPS_PER_STAGE(1), .SIGNED(0)) u_dut_u1 (.clock(clock), .reset_n(reset_n), .bus(if_u1));
    normalize_pipe #(.WIDTH(16), .STEPS_PER_STAGE(2), .SIGNED(0)) u_dut_u2 (.clock(clock), .reset_n(reset_n), .bus(if_u2));
    normalize_pipe #(.WIDTH(16), .STEPS_PER_STAGE(4), .SIGNED(0)) u_dut_u4 (.clock(clock), .reset_n(reset_n), .bus(if_u4));
    normalize_pipe #(.WIDTH(16), .STEPS_PER_STAGE(1), .SIGNED(1)) u_dut_s1 (.clock(clock), .reset_n(reset_n), .bus(if_s1));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] din;
        logic [15:0] u_data;
        logic [3:0]  u_norm;
        logic        u_zero;
        logic [15:0] s_data;
        logic [3:0]  s_norm;
        logic        s_zero;
    } vec_t;

    vec_t vecs [12];
    vec_t v_after_rst;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] ref_norm(input logic [15:0] x, input bit sgn);
        int n;
        n = 0;
        if (sgn) begin
            for (int i = 14; i >= 0; i--)
                if (x[i] == x[15] && n == 14 - i) n++;
        end else begin
            for (int i = 15; i >= 0; i--)
                if (x[i] == 1'b0 && n == 15 - i) n++;
        end
        if (n > 15) n = 15;
        return n[3:0];
    endfunction

    task automatic set_all(input logic [15:0] d, input logic v, input logic r);
        if_u1.data_i = d; if_u1.valid_i = v; if_u1.ready_i = r;
        if_u2.data_i = d; if_u2.valid_i = v; if_u2.ready_i = r;
        if_u4.data_i = d; if_u4.valid_i = v; if_u4.ready_i = r;
        if_s1.data_i = d; if_s1.valid_i = v; if_s1.ready_i = r;
    endtask

    // One item into all four DUTs; capture the first valid_o of each and its latency.
    task automatic run_vec(input string tag, input vec_t v);
        int          lat [4];
        logic [15:0] cd  [4];
        logic [3:0]  cn  [4];
        logic        cz  [4];
        int          exp_lat [4];
        exp_lat[0] = 4; exp_lat[1] = 2; exp_lat[2] = 1; exp_lat[3] = 4;
        for (int d = 0; d < 4; d++) begin
            lat[d] = 0; cd[d] = '0; cn[d] = '0; cz[d] = 1'b0;
        end
        @(negedge clock);
        set_all(v.din, 1'b1, 1'b1);
        chk({tag, ".ready_o"}, {31'd0, if_u1.ready_o}, 32'd1);
        @(posedge clock);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            #1;
            if (cyc == 1) set_all(16'h0000, 1'b0, 1'b1);
            if (if_u1.valid_o && lat[0] == 0) begin lat[0] = cyc; cd[0] = if_u1.data_o; cn[0] = if_u1.norm_o; cz[0] = if_u1.zero_o; end
            if (if_u2.valid_o && lat[1] == 0) begin lat[1] = cyc; cd[1] = if_u2.data_o; cn[1] = if_u2.norm_o; cz[1] = if_u2.zero_o; end
            if (if_u4.valid_o && lat[2] == 0) begin lat[2] = cyc; cd[2] = if_u4.data_o; cn[2] = if_u4.norm_o; cz[2] = if_u4.zero_o; end
            if (if_s1.valid_o && lat[3] == 0) begin lat[3] = cyc; cd[3] = if_s1.data_o; cn[3] = if_s1.norm_o; cz[3] = if_s1.zero_o; end
            @(posedge clock);
        end
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("%s.dut%0d.latency", tag, d), lat[d], exp_lat[d]);
            chk($sformatf("%s.dut%0d.data", tag, d), {16'd0, cd[d]}, (d == 3) ? {16'd0, v.s_data} : {16'd0, v.u_data});
            chk($sformatf("%s.dut%0d.norm", tag, d), {28'd0, cn[d]}, (d == 3) ? {28'd0, v.s_norm} : {28'd0, v.u_norm});
            chk($sformatf("%s.dut%0d.zero", tag, d), {31'd0, cz[d]}, (d == 3) ? {31'd0, v.s_zero} : {31'd0, v.u_zero});
        end
    endtask

    initial begin : main
        logic [15:0] stream [20];
        logic [15:0] q_data [$];
        logic [3:0]  q_norm [$];
        logic        q_zero [$];
        logic [15:0] p_data;
        logic [3:0]  p_norm;
        logic        p_zero;
        bit          prev_stall;
        int          sent;
        int          rcvd;
        int          cyc;
        logic [15:0] e_data;
        logic [3:0]  e_norm;

        //           din       u_data    un  uz  s_data    sn  sz
        vecs[0]  = '{16'h0001, 16'h8000, 15, 0, 16'h4000, 14, 0};
        vecs[1]  = '{16'h0000, 16'h0000, 15, 1, 16'h0000, 15, 1};
        vecs[2]  = '{16'h8000, 16'h8000,  0, 0, 16'h8000,  0, 0};
        vecs[3]  = '{16'h00F0, 16'hF000,  8, 0, 16'h7800,  7, 0};
        vecs[4]  = '{16'h0003, 16'hC000, 14, 0, 16'h6000, 13, 0};
        vecs[5]  = '{16'hFFFE, 16'hFFFE,  0, 0, 16'h8000, 14, 0};
        vecs[6]  = '{16'hFFFF, 16'hFFFF,  0, 0, 16'h8000, 15, 1};
        vecs[7]  = '{16'h0100, 16'h8000,  7, 0, 16'h4000,  6, 0};
        vecs[8]  = '{16'h4000, 16'h8000,  1, 0, 16'h4000,  0, 0};
        vecs[9]  = '{16'hC000, 16'hC000,  0, 0, 16'h8000,  1, 0};
        vecs[10] = '{16'h0800, 16'h8000,  4, 0, 16'h4000,  3, 0};
        vecs[11] = '{16'hFF80, 16'hFF80,  0, 0, 16'h8000,  8, 0};
        v_after_rst = vecs[7];

        reset_n = 1'b0;
        set_all(16'h0000, 1'b0, 1'b1);
        #1;
        chk("rst.valid_o", {31'd0, if_u1.valid_o}, 32'd0);
        chk("rst.data_o",  {16'd0, if_u1.data_o},  32'd0);
        chk("rst.norm_o",  {28'd0, if_u1.norm_o},  32'd0);
        chk("rst.zero_o",  {31'd0, if_u1.zero_o},  32'd0);
        chk("rst.ready_o", {31'd0, if_u1.ready_o}, 32'd1);
        chk("rst.s1.valid_o", {31'd0, if_s1.valid_o}, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Random stream with random back-pressure on the 1-step unsigned pipe.
        for (int i = 0; i < 20; i++) stream[i] = 16'($urandom) >> $urandom_range(0, 15);
        sent = 0; rcvd = 0; cyc = 0; prev_stall = 1'b0;
        p_data = '0; p_norm = '0; p_zero = 1'b0;
        @(posedge clock);
        #1;
        while ((sent < 20 || rcvd < 20) && cyc < 600) begin
            if (prev_stall) begin
                chk("stream.hold.valid", {31'd0, if_u1.valid_o}, 32'd1);
                chk("stream.hold.data",  {16'd0, if_u1.data_o},  {16'd0, p_data});
                chk("stream.hold.norm",  {28'd0, if_u1.norm_o},  {28'd0, p_norm});
                chk("stream.hold.zero",  {31'd0, if_u1.zero_o},  {31'd0, p_zero});
            end
            if_u1.ready_i = 1'($urandom_range(0, 1));
            if (sent < 20 && $urandom_range(0, 3) != 0) begin
                if_u1.valid_i = 1'b1;
                if_u1.data_i  = stream[sent];
            end else begin
                if_u1.valid_i = 1'b0;
            end
            #1;
            chk("stream.ready_o", {31'd0, if_u1.ready_o}, {31'd0, (if_u1.ready_i | ~if_u1.valid_o)});
            if (if_u1.valid_o && if_u1.ready_i) begin
                if (q_data.size() == 0) begin
                    chk("stream.unexpected_output", 32'd1, 32'd0);
                end else begin
                    chk($sformatf("stream.out%0d.data", rcvd), {16'd0, if_u1.data_o}, {16'd0, q_data.pop_front()});
                    chk($sformatf("stream.out%0d.norm", rcvd), {28'd0, if_u1.norm_o}, {28'd0, q_norm.pop_front()});
                    chk($sformatf("stream.out%0d.zero", rcvd), {31'd0, if_u1.zero_o}, {31'd0, q_zero.pop_front()});
                end
                rcvd++;
            end
            prev_stall = if_u1.valid_o && !if_u1.ready_i;
            p_data = if_u1.data_o; p_norm = if_u1.norm_o; p_zero = if_u1.zero_o;
            if (if_u1.valid_i && if_u1.ready_o) begin
                e_norm = ref_norm(if_u1.data_i, 1'b0);
                e_data = if_u1.data_i << e_norm;
                q_data.push_back(e_data);
                q_norm.push_back(e_norm);
                q_zero.push_back(if_u1.data_i == 16'h0000);
                sent++;
            end
            @(posedge clock);
            #1;
            cyc++;
        end
        chk("stream.received", rcvd, 32'd20);
        if_u1.valid_i = 1'b0;
        if_u1.ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock); #1;
            chk("stream.drain.no_dup", {31'd0, if_u1.valid_o}, 32'd0);
        end

        // Reset pulse with items in flight and one held at the output.
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if_u1.valid_i = 1'b1;
            if_u1.ready_i = 1'b1;
            if_u1.data_i  = 16'h0001 << i;
        end
        @(posedge clock); #1;
        if_u1.valid_i = 1'b0;
        if_u1.ready_i = 1'b0;
        chk("rstpulse.pre.valid_o", {31'd0, if_u1.valid_o}, 32'd1);
        chk("rstpulse.pre.data_o",  {16'd0, if_u1.data_o},  32'h8000);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rstpulse.valid_o", {31'd0, if_u1.valid_o}, 32'd0);
        chk("rstpulse.data_o",  {16'd0, if_u1.data_o},  32'd0);
        chk("rstpulse.norm_o",  {28'd0, if_u1.norm_o},  32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        if_u1.ready_i = 1'b1;
        #1;
        chk("rstpulse.ready_o", {31'd0, if_u1.ready_o}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clock); #1;
            chk("rstpulse.no_stale", {31'd0, if_u1.valid_o}, 32'd0);
        end
        run_vec("after_rst", v_after_rst);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
